// File: rtl/core_acc_arb_pkg.sv
// Shared types for the accumulator arbiter: one-hot FSM encodings and the requester-ID width helper.
package core_acc_arb_pkg;

   typedef enum logic [2:0] {
      ARB_IDLE  = 3'b001,
      ARB_BURST = 3'b010,
      ARB_WAIT  = 3'b100
   } arb_state_t;

   function automatic int id_width(input int num_req);
      return (num_req <= 2) ? 1 : $clog2(num_req);
   endfunction

endpackage

// File: rtl/core_acc_arb_if.sv
// Bundle of requester, accumulator and result signals around core_acc_arb.
interface core_acc_arb_if
   import core_acc_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int IDATA_BIT = 32,
   parameter int ODATA_BIT = 32,
   localparam int ID_W     = id_width(NUM_REQ)
) ();

   // Requester beats transfer on a cycle where req_valid[i] & req_ready[i]; acc_idata_valid,
   // acc_odata_valid and res_valid are single-cycle strobes with no back-pressure.
   logic [NUM_REQ*IDATA_BIT-1:0] req_psum;
   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ-1:0]           req_ready;
   logic [IDATA_BIT-1:0]         acc_idata;
   logic                         acc_idata_valid;
   logic [ODATA_BIT-1:0]         acc_odata;
   logic                         acc_odata_valid;
   logic [ODATA_BIT-1:0]         res_data;
   logic [ID_W-1:0]              res_id;
   logic                         res_valid;

   modport slave (
      input  req_psum, req_valid, acc_odata, acc_odata_valid,
      output req_ready, acc_idata, acc_idata_valid, res_data, res_id, res_valid
   );

   modport master (
      output req_psum, req_valid, acc_odata, acc_odata_valid,
      input  req_ready, acc_idata, acc_idata_valid, res_data, res_id, res_valid
   );

endinterface

// File: rtl/core_acc_arb_rr.sv
// Round-robin picker: first valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
module core_acc_arb_rr
   import core_acc_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   localparam int ID_W   = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [ID_W-1:0]    rr_ptr,
   input  logic               grant_en,
   output logic [ID_W-1:0]    grant_id,
   output logic               grant_any
);

   logic [ID_W-1:0] idx;

   // NUM_REQ is a power of two, so ID_W-bit addition wraps for free.
   always_comb begin
      grant_id  = '0;
      grant_any = 1'b0;
      idx       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = rr_ptr + ID_W'(i);
         if (grant_en && !grant_any && req_valid[idx]) begin
            grant_any = 1'b1;
            grant_id  = idx;
         end
      end
   end

endmodule

// File: rtl/core_acc_arb.sv
// Shares one accumulator among NUM_REQ psum requesters, one whole burst per grant.
// Optional per-requester completed-burst counters under CORE_ACC_ARB_STAT_EN.
module core_acc_arb
   import core_acc_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int IDATA_BIT = 32,
   parameter int ODATA_BIT = 32,
   parameter int CDATA_BIT = 8
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [CDATA_BIT-1:0] cfg_acc_num,
   core_acc_arb_if.slave        bus,
   output logic                 busy,
   output arb_state_t           state_dbg
`ifdef CORE_ACC_ARB_STAT_EN
   ,
   output logic [NUM_REQ*16-1:0] stat_grant_cnt
`endif
);

   localparam int ID_W = id_width(NUM_REQ);
   localparam logic [NUM_REQ-1:0] ONE_MASK = {{(NUM_REQ-1){1'b0}}, 1'b1};

   arb_state_t           state;
   logic [ID_W-1:0]      grant_id;
   logic [ID_W-1:0]      rr_ptr;
   logic [ID_W-1:0]      pick_id;
   logic                 pick_any;
   logic                 grant_en;
   logic [CDATA_BIT-1:0] burst_len;
   logic [CDATA_BIT-1:0] beat_cnt;
   logic                 hs;

   assign grant_en  = (state == ARB_IDLE);
   assign hs        = (state == ARB_BURST) && bus.req_valid[grant_id];
   assign state_dbg = state;

   // Only the owner sees ready, and only while it is actually presenting a beat.
   assign bus.req_ready = (state == ARB_BURST) ? (bus.req_valid & (ONE_MASK << grant_id)) : '0;

   core_acc_arb_rr #(.NUM_REQ(NUM_REQ)) u_rr (
      .req_valid (bus.req_valid),
      .rr_ptr    (rr_ptr),
      .grant_en  (grant_en),
      .grant_id  (pick_id),
      .grant_any (pick_any)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state               <= ARB_IDLE;
         grant_id            <= '0;
         rr_ptr              <= '0;
         burst_len           <= '0;
         beat_cnt            <= '0;
         busy                <= 1'b0;
         bus.acc_idata       <= '0;
         bus.acc_idata_valid <= 1'b0;
         bus.res_data        <= '0;
         bus.res_id          <= '0;
         bus.res_valid       <= 1'b0;
      end else begin
         bus.acc_idata_valid <= 1'b0;
         bus.res_valid       <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (pick_any) begin
                  grant_id  <= pick_id;
                  // A zero beat count still means one beat, so a burst always terminates.
                  burst_len <= (cfg_acc_num == '0) ? CDATA_BIT'(1) : cfg_acc_num;
                  busy      <= 1'b1;
                  state     <= ARB_BURST;
               end
            end
            ARB_BURST: begin
               if (hs) begin
                  bus.acc_idata       <= bus.req_psum[grant_id*IDATA_BIT +: IDATA_BIT];
                  bus.acc_idata_valid <= 1'b1;
                  if (beat_cnt == burst_len - 1'b1) begin
                     beat_cnt <= '0;
                     state    <= ARB_WAIT;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            ARB_WAIT: begin
               if (bus.acc_odata_valid) begin
                  bus.res_data  <= bus.acc_odata;
                  bus.res_id    <= grant_id;
                  bus.res_valid <= 1'b1;
                  rr_ptr        <= grant_id + 1'b1;
                  busy          <= 1'b0;
                  state         <= ARB_IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= ARB_IDLE;
            end
         endcase
      end
   end

`ifdef CORE_ACC_ARB_STAT_EN
   logic [NUM_REQ-1:0][15:0] stat_cnt;

   // Counts a burst at the same edge its result strobe is launched.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stat_cnt <= '0;
      end else if (state == ARB_WAIT && bus.acc_odata_valid && stat_cnt[grant_id] != 16'hFFFF) begin
         stat_cnt[grant_id] <= stat_cnt[grant_id] + 16'd1;
      end
   end

   assign stat_grant_cnt = stat_cnt;
`endif

endmodule

// File: tb/tb_core_acc_arb.sv
// Directed bench for core_acc_arb with expected-result queues and a small accumulator model.
module tb_core_acc_arb;
   import core_acc_arb_pkg::*;

   localparam int NUM_REQ   = 4;
   localparam int IDATA_BIT = 32;
   localparam int ODATA_BIT = 32;
   localparam int CDATA_BIT = 8;
   localparam int ID_W      = 2;

   logic                 clk = 1'b0;
   logic                 rstn;
   logic [CDATA_BIT-1:0] cfg_acc_num;
   logic                 busy;
   arb_state_t           state_dbg;
`ifdef CORE_ACC_ARB_STAT_EN
   logic [NUM_REQ*16-1:0] stat_grant_cnt;
`endif

   core_acc_arb_if #(.NUM_REQ(NUM_REQ), .IDATA_BIT(IDATA_BIT), .ODATA_BIT(ODATA_BIT)) bus ();

   core_acc_arb #(
      .NUM_REQ(NUM_REQ), .IDATA_BIT(IDATA_BIT), .ODATA_BIT(ODATA_BIT), .CDATA_BIT(CDATA_BIT)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .cfg_acc_num (cfg_acc_num),
      .bus         (bus.slave),
      .busy        (busy),
      .state_dbg   (state_dbg)
`ifdef CORE_ACC_ARB_STAT_EN
      ,
      .stat_grant_cnt (stat_grant_cnt)
`endif
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- bench state ----------------
   int errors = 0;
   int checks = 0;
   logic [ID_W+ODATA_BIT-1:0] exp_q[$];
   logic [IDATA_BIT-1:0]      beat_q[$];
   int                        src_left[NUM_REQ];
   logic [IDATA_BIT-1:0]      src_val[NUM_REQ];
   logic [NUM_REQ-1:0]        hs_s;
   logic [NUM_REQ-1:0]        forbid_mask;
   int                        acc_n, acc_cnt, acc_delay;
   logic [ODATA_BIT-1:0]      acc_sum, acc_ret;
   int                        res_cnt;
   logic                      prev_res;
   int                        tally[NUM_REQ];

   always @(posedge clk) hs_s <= bus.req_valid & bus.req_ready;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_burst(input logic [ID_W-1:0] id, input logic [IDATA_BIT-1:0] start, input int n);
      logic [ODATA_BIT-1:0] sum;
      sum = '0;
      for (int k = 0; k < n; k++) begin
         beat_q.push_back(start + IDATA_BIT'(k));
         sum = sum + ODATA_BIT'(start + IDATA_BIT'(k));
      end
      exp_q.push_back({id, sum});
   endtask

   // One clock: observe outputs, run the accumulator model, advance and drive requesters.
   task automatic tick();
      logic [ID_W+ODATA_BIT-1:0] e;
      @(negedge clk);
      if (forbid_mask != '0)
         check("ready_forbid", 64'(bus.req_ready & forbid_mask), 64'(0));
      if (bus.res_valid) begin
         check("res_pulse_len", 64'(prev_res), 64'(0));
         if (exp_q.size() == 0) begin
            check("res_unexpected", 64'(bus.res_valid), 64'(0));
         end else begin
            e = exp_q.pop_front();
            check("res_id", 64'(bus.res_id), 64'(e[ODATA_BIT +: ID_W]));
            check("res_data", 64'(bus.res_data), 64'(e[ODATA_BIT-1:0]));
            tally[e[ODATA_BIT +: ID_W]]++;
         end
         res_cnt++;
         forbid_mask = '0;
      end
      prev_res = bus.res_valid;

      bus.acc_odata_valid = 1'b0;
      if (acc_delay > 0) begin
         acc_delay--;
         if (acc_delay == 0) begin
            bus.acc_odata_valid = 1'b1;
            bus.acc_odata       = acc_ret;
         end
      end
      if (bus.acc_idata_valid) begin
         if (beat_q.size() == 0)
            check("beat_unexpected", 64'(bus.acc_idata_valid), 64'(0));
         else
            check("beat_data", 64'(bus.acc_idata), 64'(beat_q.pop_front()));
         acc_sum = acc_sum + ODATA_BIT'(bus.acc_idata);
         acc_cnt++;
         if (acc_cnt == acc_n) begin
            acc_ret   = acc_sum;
            acc_sum   = '0;
            acc_cnt   = 0;
            acc_delay = 3;
         end
      end

      for (int i = 0; i < NUM_REQ; i++) begin
         if (hs_s[i]) begin
            src_left[i]--;
            src_val[i] = src_val[i] + 1'b1;
         end
         bus.req_valid[i] = (src_left[i] > 0);
         bus.req_psum[i*IDATA_BIT +: IDATA_BIT] = src_val[i];
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < NUM_REQ; i++) begin
         src_left[i] = 0;
         tally[i]    = 0;
      end
      acc_cnt     = 0;
      acc_sum     = '0;
      acc_delay   = 0;
      forbid_mask = '0;
      prev_res    = 1'b0;
      beat_q.delete();
      exp_q.delete();
   endtask

   task automatic reset_dut();
      rstn = 1'b0;
      clear_model();
      tick();
      tick();
      rstn = 1'b1;
   endtask

   task automatic drain(input string tag, input int budget);
      int c;
      c = 0;
      while ((busy || exp_q.size() != 0) && c < budget) begin
         tick();
         c++;
      end
      check({tag, "_results_left"}, 64'(exp_q.size()), 64'(0));
      check({tag, "_beats_left"}, 64'(beat_q.size()), 64'(0));
      check({tag, "_busy"}, 64'(busy), 64'(0));
      check({tag, "_state"}, 64'(state_dbg), 64'(ARB_IDLE));
   endtask

   task automatic wait_left(input string tag, input int id, input int target);
      int c;
      c = 0;
      while (src_left[id] != target && c < 100) begin
         tick();
         c++;
      end
      check(tag, 64'(src_left[id]), 64'(target));
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int start;
      rstn                = 1'b0;
      cfg_acc_num         = '0;
      bus.req_valid       = '0;
      bus.req_psum        = '0;
      bus.acc_odata       = '0;
      bus.acc_odata_valid = 1'b0;
      res_cnt             = 0;
      acc_n               = 1;
      for (int i = 0; i < NUM_REQ; i++) src_val[i] = '0;
      clear_model();
      repeat (3) @(negedge clk);

      check("rst_busy", 64'(busy), 64'(0));
      check("rst_state", 64'(state_dbg), 64'(ARB_IDLE));
      check("rst_req_ready", 64'(bus.req_ready), 64'(0));
      check("rst_acc_valid", 64'(bus.acc_idata_valid), 64'(0));
      check("rst_acc_idata", 64'(bus.acc_idata), 64'(0));
      check("rst_res_valid", 64'(bus.res_valid), 64'(0));
      check("rst_res_data", 64'(bus.res_data), 64'(0));
      check("rst_res_id", 64'(bus.res_id), 64'(0));
      rstn = 1'b1;

      // Single requester 2, four beats 1..4 -> result 10
      cfg_acc_num = 8'd4; acc_n = 4;
      src_val[2] = 32'd1; src_left[2] = 4;
      expect_burst(2'd2, 32'd1, 4);
      start = res_cnt;
      drain("t1", 200);
      check("t1_res_count", 64'(res_cnt - start), 64'(1));

      // All four valid, two beats each, two rounds -> order 0,1,2,3,0,1,2,3
      reset_dut();
      cfg_acc_num = 8'd2; acc_n = 2;
      for (int i = 0; i < NUM_REQ; i++) begin
         src_val[i]  = IDATA_BIT'(i * 16 + 1);
         src_left[i] = 4;
      end
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < NUM_REQ; i++)
            expect_burst(ID_W'(i), IDATA_BIT'(i * 16 + 1 + r * 2), 2);
      drain("t2", 400);

      // Owner 1 stalls after its first beat while 3 waits
      cfg_acc_num = 8'd3; acc_n = 3;
      src_val[1] = 32'd1;   src_left[1] = 1;
      src_val[3] = 32'd101; src_left[3] = 3;
      forbid_mask = 4'b1000;
      expect_burst(2'd1, 32'd1, 3);
      expect_burst(2'd3, 32'd101, 3);
      wait_left("t3_first_beat", 1, 0);
      repeat (5) tick();
      check("t3_grant_held", 64'(state_dbg), 64'(ARB_BURST));
      src_left[1] = 2;
      drain("t3", 200);

      // cfg_acc_num == 0 behaves as one beat per burst
      cfg_acc_num = 8'd0; acc_n = 1;
      src_val[0] = 32'd5; src_left[0] = 2;
      expect_burst(2'd0, 32'd5, 1);
      expect_burst(2'd0, 32'd6, 1);
      drain("t4a", 200);

      // Changing cfg mid-burst must not stretch the latched length
      cfg_acc_num = 8'd4; acc_n = 4;
      src_val[2] = 32'd50; src_left[2] = 4;
      expect_burst(2'd2, 32'd50, 4);
      wait_left("t4b_two_beats", 2, 2);
      cfg_acc_num = 8'd8;
      drain("t4b", 200);
      cfg_acc_num = 8'd4;

      // Reset mid-burst after two beats; pointer must restart at 0
      acc_n = 4;
      src_val[1] = 32'd201; src_left[1] = 4;
      beat_q.push_back(32'd201);
      beat_q.push_back(32'd202);
      wait_left("t5_two_beats", 1, 2);
      check("t5_beats_seen", 64'(beat_q.size()), 64'(0));
      rstn = 1'b0;
      clear_model();
      tick();
      check("t5_rst_busy", 64'(busy), 64'(0));
      check("t5_rst_state", 64'(state_dbg), 64'(ARB_IDLE));
      check("t5_rst_acc_valid", 64'(bus.acc_idata_valid), 64'(0));
      check("t5_rst_acc_idata", 64'(bus.acc_idata), 64'(0));
      check("t5_rst_res_valid", 64'(bus.res_valid), 64'(0));
      tick();
      rstn = 1'b1;
      src_val[1] = 32'd203; src_left[1] = 4;
      src_val[3] = 32'd301; src_left[3] = 4;
      expect_burst(2'd1, 32'd203, 4);
      expect_burst(2'd3, 32'd301, 4);
      drain("t5", 300);

      // Stray accumulator strobe while idle produces no result
      start = res_cnt;
      bus.acc_odata       = 32'hdead_beef;
      bus.acc_odata_valid = 1'b1;
      repeat (4) tick();
      check("t6_no_res", 64'(res_cnt - start), 64'(0));
      check("t6_res_data", 64'(bus.res_data), 64'(32'd1210));
      check("t6_state", 64'(state_dbg), 64'(ARB_IDLE));

`ifdef CORE_ACC_ARB_STAT_EN
      for (int i = 0; i < NUM_REQ; i++)
         check("stat_cnt", 64'(stat_grant_cnt[i*16 +: 16]), 64'(tally[i]));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
